// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared core constants, opcode/flag indices and CCR shadow FSM encoding
//
// Purpose: common definitions for the EX->MEM stage and its CCR unit.
//  DW/RW/OPW      datapath, register-index and one-hot opcode widths
//  OP_*           bit positions inside the one-hot ALU opcode
//  FLG_*          bit positions inside the {C,N,Z} condition-code register
//  shadow_state_t CCR shadow FSM states (used when CCR_SHADOW_EN is defined)
package cpu_pkg;

  localparam int DW  = 16;
  localparam int RW  = 3;
  localparam int OPW = 13;

  localparam int OP_DEC = 0;
  localparam int OP_INC = 1;
  localparam int OP_SHR = 2;
  localparam int OP_SHL = 3;
  localparam int OP_OR  = 4;
  localparam int OP_AND = 5;
  localparam int OP_SUB = 6;
  localparam int OP_ADD = 7;
  localparam int OP_MOV = 8;
  localparam int OP_NOT = 9;
  localparam int OP_NOP = 10;
  localparam int OP_IN  = 11;
  localparam int OP_OUT = 12;

  localparam int FLG_Z = 0;
  localparam int FLG_N = 1;
  localparam int FLG_C = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SAVED = 1'b1
  } shadow_state_t;

  // Exactly one bit set; zero-hot and multi-hot opcodes leave the CCR alone.
  function automatic logic is_onehot(input logic [OPW-1:0] v);
    return (v != '0) && ((v & (v - OPW'(1))) == '0);
  endfunction

endpackage

// File: rtl/ccr_unit.sv
// rtl/ccr_unit.sv - next-CCR logic, optional interrupt shadow FSM and CCR register
//
// Purpose: holds the architectural {C,N,Z} register and applies per-opcode update rules.
// Optional feature macro: CCR_SHADOW_EN (one-deep CCR save/restore around interrupts).
// Ports:
//  clk, rst          clock, synchronous active-high reset
//  accept            instruction leaves EX this edge (already excludes stall/flush)
//  alu_result        ALU result, used for Z/N
//  alu_carry         ALU carry out
//  alu_op            one-hot opcode
//  setc, clrc        force C to 1 / 0 (setc wins)
//  int_save          interrupt taken: save CCR (CCR_SHADOW_EN only)
//  int_restore       RTI: restore CCR (CCR_SHADOW_EN only)
//  ccr               registered {C,N,Z}
module ccr_unit
  import cpu_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          accept,
  input  logic [DW-1:0] alu_result,
  input  logic          alu_carry,
  input  logic [OPW-1:0] alu_op,
  input  logic          setc,
  input  logic          clrc,
  input  logic          int_save,
  input  logic          int_restore,
  output logic [2:0]    ccr
);

  logic [2:0] ccr_next;
  logic       upd_zn;
  logic       upd_c;
  logic       restore_fire;
  logic [2:0] restore_val;

  always_comb begin
    upd_zn = 1'b0;
    upd_c  = 1'b0;
    if (is_onehot(alu_op)) begin
      upd_zn = alu_op[OP_NOT] | alu_op[OP_ADD] | alu_op[OP_SUB] | alu_op[OP_AND] |
               alu_op[OP_OR]  | alu_op[OP_INC] | alu_op[OP_DEC] | alu_op[OP_SHL] |
               alu_op[OP_SHR];
      upd_c  = alu_op[OP_ADD] | alu_op[OP_INC] | alu_op[OP_SHL] | alu_op[OP_SHR];
    end

    ccr_next = ccr;
    if (upd_zn) begin
      ccr_next[FLG_Z] = (alu_result == '0);
      ccr_next[FLG_N] = alu_result[DW-1];
    end
    if (upd_c) begin
      ccr_next[FLG_C] = alu_carry;
    end
    // Explicit carry instructions override whatever the opcode did to C.
    if (setc) begin
      ccr_next[FLG_C] = 1'b1;
    end else if (clrc) begin
      ccr_next[FLG_C] = 1'b0;
    end
  end

`ifdef CCR_SHADOW_EN
  shadow_state_t state;
  logic [2:0]    shadow;

  assign restore_fire = (state == ST_SAVED) && int_restore;
  assign restore_val  = shadow;

  // Save captures the CCR as it stands before this edge's instruction update.
  // A same-cycle restore suppresses the save; only one level of nesting.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      shadow <= 3'b000;
    end else begin
      case (state)
        ST_IDLE: begin
          if (int_save && !int_restore) begin
            shadow <= ccr;
            state  <= ST_SAVED;
          end
        end
        ST_SAVED: begin
          if (int_restore) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
`else
  logic unused_int;
  assign unused_int   = int_save ^ int_restore;
  assign restore_fire = 1'b0;
  assign restore_val  = 3'b000;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      ccr <= 3'b000;
    end else if (restore_fire) begin
      ccr <= restore_val;
    end else if (accept) begin
      ccr <= ccr_next;
    end
  end

endmodule

// File: rtl/ex_mem_stage.sv
// rtl/ex_mem_stage.sv - EX->MEM pipeline register with CCR and forwarding source
//
// Purpose: registers ALU result and control fields into MEM, owns the CCR via ccr_unit,
// supports stall/flush and drives the MEM->EX forwarding path.
// Optional feature macro: CCR_SHADOW_EN (passed through to ccr_unit).
// Ports:
//  clk, rst                       clock, synchronous active-high reset
//  ex_valid, ex_ready             EX handshake; ex_ready = !mem_stall
//  alu_result, alu_carry, alu_op  ALU outputs and one-hot opcode
//  ex_rdst, ex_reg_write, ex_mem_read, ex_mem_write, ex_setc, ex_clrc   EX control
//  mem_stall, flush               hold stage / squash EX instruction
//  int_save, int_restore          CCR shadow control
//  mem_*                          registered MEM-stage fields
//  ccr                            {C,N,Z}
//  fwd_valid, fwd_rdst, fwd_data  forwarding source to EX
module ex_mem_stage
  import cpu_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           ex_valid,
  output logic           ex_ready,
  input  logic [DW-1:0]  alu_result,
  input  logic           alu_carry,
  input  logic [OPW-1:0] alu_op,
  input  logic [RW-1:0]  ex_rdst,
  input  logic           ex_reg_write,
  input  logic           ex_mem_read,
  input  logic           ex_mem_write,
  input  logic           ex_setc,
  input  logic           ex_clrc,
  input  logic           mem_stall,
  input  logic           flush,
  input  logic           int_save,
  input  logic           int_restore,
  output logic           mem_valid,
  output logic [DW-1:0]  mem_result,
  output logic [RW-1:0]  mem_rdst,
  output logic           mem_reg_write,
  output logic           mem_mem_read,
  output logic           mem_mem_write,
  output logic [2:0]     ccr,
  output logic           fwd_valid,
  output logic [RW-1:0]  fwd_rdst,
  output logic [DW-1:0]  fwd_data
);

  logic accept;

  assign ex_ready = !mem_stall;
  assign accept   = ex_valid && !flush && !mem_stall;

  // Controls are gated with accept so a bubble can never write state downstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_valid     <= 1'b0;
      mem_result    <= '0;
      mem_rdst      <= '0;
      mem_reg_write <= 1'b0;
      mem_mem_read  <= 1'b0;
      mem_mem_write <= 1'b0;
    end else if (!mem_stall) begin
      mem_valid     <= accept;
      mem_result    <= alu_result;
      mem_rdst      <= ex_rdst;
      mem_reg_write <= accept && ex_reg_write;
      mem_mem_read  <= accept && ex_mem_read;
      mem_mem_write <= accept && ex_mem_write;
    end
  end

  ccr_unit u_ccr (
    .clk         (clk),
    .rst         (rst),
    .accept      (accept),
    .alu_result  (alu_result),
    .alu_carry   (alu_carry),
    .alu_op      (alu_op),
    .setc        (ex_setc),
    .clrc        (ex_clrc),
    .int_save    (int_save),
    .int_restore (int_restore),
    .ccr         (ccr)
  );

  assign fwd_valid = mem_valid && mem_reg_write;
  assign fwd_rdst  = mem_rdst;
  assign fwd_data  = mem_result;

endmodule

// File: tb/tb_ex_mem_stage.sv
// tb/tb_ex_mem_stage.sv - directed self-checking bench for ex_mem_stage
module tb_ex_mem_stage;
  import cpu_pkg::*;

  logic           clk = 1'b0;
  logic           rst;
  logic           ex_valid;
  logic           ex_ready;
  logic [DW-1:0]  alu_result;
  logic           alu_carry;
  logic [OPW-1:0] alu_op;
  logic [RW-1:0]  ex_rdst;
  logic           ex_reg_write;
  logic           ex_mem_read;
  logic           ex_mem_write;
  logic           ex_setc;
  logic           ex_clrc;
  logic           mem_stall;
  logic           flush;
  logic           int_save;
  logic           int_restore;
  logic           mem_valid;
  logic [DW-1:0]  mem_result;
  logic [RW-1:0]  mem_rdst;
  logic           mem_reg_write;
  logic           mem_mem_read;
  logic           mem_mem_write;
  logic [2:0]     ccr;
  logic           fwd_valid;
  logic [RW-1:0]  fwd_rdst;
  logic [DW-1:0]  fwd_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ex_mem_stage dut (
    .clk           (clk),
    .rst           (rst),
    .ex_valid      (ex_valid),
    .ex_ready      (ex_ready),
    .alu_result    (alu_result),
    .alu_carry     (alu_carry),
    .alu_op        (alu_op),
    .ex_rdst       (ex_rdst),
    .ex_reg_write  (ex_reg_write),
    .ex_mem_read   (ex_mem_read),
    .ex_mem_write  (ex_mem_write),
    .ex_setc       (ex_setc),
    .ex_clrc       (ex_clrc),
    .mem_stall     (mem_stall),
    .flush         (flush),
    .int_save      (int_save),
    .int_restore   (int_restore),
    .mem_valid     (mem_valid),
    .mem_result    (mem_result),
    .mem_rdst      (mem_rdst),
    .mem_reg_write (mem_reg_write),
    .mem_mem_read  (mem_mem_read),
    .mem_mem_write (mem_mem_write),
    .ccr           (ccr),
    .fwd_valid     (fwd_valid),
    .fwd_rdst      (fwd_rdst),
    .fwd_data      (fwd_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One active edge, then settle away from it before sampling or driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int op, input logic [DW-1:0] res, input logic cy,
                       input logic [RW-1:0] rd, input logic rw);
    ex_valid     = 1'b1;
    alu_op       = OPW'(1) << op;
    alu_result   = res;
    alu_carry    = cy;
    ex_rdst      = rd;
    ex_reg_write = rw;
    ex_mem_read  = 1'b0;
    ex_mem_write = 1'b0;
    ex_setc      = 1'b0;
    ex_clrc      = 1'b0;
  endtask

  task automatic idle();
    ex_valid     = 1'b0;
    alu_op       = '0;
    alu_result   = '0;
    alu_carry    = 1'b0;
    ex_rdst      = '0;
    ex_reg_write = 1'b0;
    ex_mem_read  = 1'b0;
    ex_mem_write = 1'b0;
    ex_setc      = 1'b0;
    ex_clrc      = 1'b0;
  endtask

  initial begin
    rst = 1'b1; mem_stall = 1'b0; flush = 1'b0; int_save = 1'b0; int_restore = 1'b0;
    idle();
    step(); step();
    check("rst_valid", 32'(mem_valid), 32'd0);
    check("rst_result", 32'(mem_result), 32'd0);
    check("rst_regwr", 32'(mem_reg_write), 32'd0);
    check("rst_ccr", 32'(ccr), 32'd0);
    check("rst_fwd", 32'(fwd_valid), 32'd0);
    check("rst_ready", 32'(ex_ready), 32'd1);
    rst = 1'b0;

    // ADD zero result with carry: Z=1, C=1
    issue(OP_ADD, 16'h0000, 1'b1, 3'd5, 1'b1);
    step();
    check("add_valid", 32'(mem_valid), 32'd1);
    check("add_result", 32'(mem_result), 32'd0);
    check("add_rdst", 32'(mem_rdst), 32'd5);
    check("add_ccr", 32'(ccr), 32'b101);
    check("add_fwd_valid", 32'(fwd_valid), 32'd1);
    check("add_fwd_rdst", 32'(fwd_rdst), 32'd5);

    // SUB negative: N=1, Z=0, C kept
    issue(OP_SUB, 16'h8000, 1'b0, 3'd2, 1'b1);
    step();
    check("sub_ccr", 32'(ccr), 32'b110);
    check("sub_fwd_data", 32'(fwd_data), 32'h8000);

    // MOV never touches the CCR
    issue(OP_MOV, 16'h0000, 1'b0, 3'd3, 1'b1);
    step();
    check("mov_ccr", 32'(ccr), 32'b110);
    check("mov_result", 32'(mem_result), 32'd0);

    // AND under a 2-cycle stall: everything holds, update lands after release
    issue(OP_AND, 16'h0001, 1'b0, 3'd4, 1'b1);
    mem_stall = 1'b1;
    #1;
    check("stall_ready", 32'(ex_ready), 32'd0);
    for (int i = 0; i < 2; i++) begin
      step();
      check("stall_result", 32'(mem_result), 32'd0);
      check("stall_rdst", 32'(mem_rdst), 32'd3);
      check("stall_ccr", 32'(ccr), 32'b110);
    end
    mem_stall = 1'b0;
    step();
    check("and_result", 32'(mem_result), 32'd1);
    check("and_rdst", 32'(mem_rdst), 32'd4);
    check("and_ccr", 32'(ccr), 32'b100);

    // flushed DEC with zero result is squashed entirely
    issue(OP_DEC, 16'h0000, 1'b0, 3'd6, 1'b1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_valid", 32'(mem_valid), 32'd0);
    check("flush_regwr", 32'(mem_reg_write), 32'd0);
    check("flush_ccr", 32'(ccr), 32'b100);
    check("flush_fwd", 32'(fwd_valid), 32'd0);

    // CLRC via NOP, then SETC+CLRC together: setc wins
    issue(OP_NOP, 16'h0000, 1'b0, 3'd0, 1'b0);
    ex_clrc = 1'b1;
    step();
    check("clrc_ccr", 32'(ccr), 32'b000);
    issue(OP_NOP, 16'h0000, 1'b0, 3'd0, 1'b0);
    ex_setc = 1'b1; ex_clrc = 1'b1;
    step();
    check("setc_ccr", 32'(ccr), 32'b100);
    check("nop_fwd", 32'(fwd_valid), 32'd0);

    // SHL sets C from carry plus Z/N
    issue(OP_SHL, 16'h8000, 1'b0, 3'd1, 1'b1);
    step();
    check("shl_ccr", 32'(ccr), 32'b010);

    // multi-hot opcode leaves CCR unchanged
    issue(OP_ADD, 16'h0000, 1'b1, 3'd1, 1'b1);
    alu_op[OP_SUB] = 1'b1;
    step();
    check("multihot_ccr", 32'(ccr), 32'b010);

    // OR store: Z=1, N=0, C kept; memory controls registered
    issue(OP_OR, 16'h0000, 1'b1, 3'd7, 1'b0);
    ex_mem_write = 1'b1;
    step();
    check("or_ccr", 32'(ccr), 32'b001);
    check("or_memwr", 32'(mem_mem_write), 32'd1);
    check("or_memrd", 32'(mem_mem_read), 32'd0);

    // bubble clears controls
    idle();
    ex_mem_write = 1'b1;
    step();
    check("bubble_valid", 32'(mem_valid), 32'd0);
    check("bubble_memwr", 32'(mem_mem_write), 32'd0);

    // interrupt save, INC changes CCR, then restore
    int_save = 1'b1;
    step();
    int_save = 1'b0;
    issue(OP_INC, 16'h8000, 1'b1, 3'd2, 1'b1);
    step();
    check("inc_ccr", 32'(ccr), 32'b110);
    idle();
    int_restore = 1'b1;
    mem_stall = 1'b1;
    step();
    int_restore = 1'b0;
    mem_stall = 1'b0;
`ifdef CCR_SHADOW_EN
    check("restore_ccr", 32'(ccr), 32'b001);
    check("restore_state", 32'(dut.u_ccr.state), 32'(ST_IDLE));
`else
    check("no_shadow_ccr", 32'(ccr), 32'b110);
`endif

    // reset mid-stream with SHL in EX
    issue(OP_SHL, 16'h1234, 1'b1, 3'd3, 1'b1);
    rst = 1'b1;
    step();
    check("mrst_valid", 32'(mem_valid), 32'd0);
    check("mrst_result", 32'(mem_result), 32'd0);
    check("mrst_rdst", 32'(mem_rdst), 32'd0);
    check("mrst_regwr", 32'(mem_reg_write), 32'd0);
    check("mrst_ccr", 32'(ccr), 32'd0);
    check("mrst_fwd", 32'(fwd_valid), 32'd0);
`ifdef CCR_SHADOW_EN
    check("mrst_state", 32'(dut.u_ccr.state), 32'(ST_IDLE));
`endif
    rst = 1'b0;
    idle();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
